// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

   localparam int ACK_TIMEOUT_DEF = 16;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   function automatic logic is_half(input logic [2:0] f3);
      return f3[1:0] == 2'b01;
   endfunction

   function automatic logic is_word(input logic [2:0] f3);
      return f3[1:0] == 2'b10;
   endfunction

   function automatic logic misaligned(
      input logic [2:0] f3,
      input logic [1:0] off
   );
      return (is_half(f3) && off[0])
          || (is_word(f3) && off != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian load extraction and read-modify-write store merge.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rd_word,
   input  logic [31:0] base_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   logic [4:0]  sh;
   logic [31:0] lane;
   logic [15:0] half;
   logic [31:0] bmask;

   assign sh    = {off, 3'b000};
   assign lane  = rd_word >> sh;
   assign half  = off[1] ? rd_word[31:16] : rd_word[15:0];
   assign bmask = 32'h0000_00FF << sh;

   always_comb begin
      load_data = rd_word;
      case (funct3)
         F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
         F3_H:    load_data = {{16{half[15]}}, half};
         F3_BU:   load_data = {24'd0, lane[7:0]};
         F3_HU:   load_data = {16'd0, half};
         default: load_data = rd_word;
      endcase
   end

   always_comb begin
      store_data = wdata;
      case (funct3[1:0])
         2'b00: store_data = (base_word & ~bmask)
                           | ({24'd0, wdata[7:0]} << sh);
         2'b01: store_data = off[1]
                           ? {wdata[15:0], base_word[15:0]}
                           : {base_word[31:16], wdata[15:0]};
         default: store_data = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store FSM: single-word memory port, sub-word stores by read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        misaligned_o,
   output logic        timeout_o,
   output logic        mem_rd_en_o,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   state_e      state, state_n;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] word_q;
   logic [CW-1:0] cnt;
   logic        mis;
   logic        expired;
   logic [31:0] load_data;
   logic [31:0] store_data;

   assign mis     = misaligned(funct3_i, addr_i[1:0]);
   assign expired = !mem_ack_i && cnt == CW'(ACK_TIMEOUT - 1);

   lsu_align u_align (
      .funct3     (f3_q),
      .off        (addr_q[1:0]),
      .rd_word    (mem_data_i),
      .base_word  (word_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n     = state;
      busy_o      = 1'b1;
      done_o      = 1'b0;
      mem_rd_en_o = 1'b0;
      mem_wr_en_o = 1'b0;
      mem_addr_o  = 32'd0;
      mem_data_o  = 32'd0;
      case (state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (req_i) begin
               if (mis)
                  state_n = S_RESP;
               else if (we_i && is_word(funct3_i))
                  state_n = S_WRITE;
               else
                  state_n = S_READ;
            end
         end
         S_READ: begin
            mem_rd_en_o = 1'b1;
            mem_addr_o  = {addr_q[31:2], 2'b00};
            if (mem_ack_i)
               state_n = we_q ? S_WRITE : S_RESP;
            else if (expired)
               state_n = S_RESP;
         end
         S_WRITE: begin
            mem_wr_en_o = 1'b1;
            mem_addr_o  = {addr_q[31:2], 2'b00};
            mem_data_o  = store_data;
            if (mem_ack_i || expired)
               state_n = S_RESP;
         end
         default: begin
            done_o  = 1'b1;
            state_n = S_IDLE;
         end
      endcase
   end

   // Counter restarts on every state change, so READ->WRITE gets a fresh budget.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (state_n != state)
         cnt <= '0;
      else if (state == S_READ || state == S_WRITE)
         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q         <= 1'b0;
         f3_q         <= 3'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         word_q       <= 32'd0;
         rdata_o      <= 32'd0;
         misaligned_o <= 1'b0;
         timeout_o    <= 1'b0;
      end else begin
         if (state == S_IDLE && req_i) begin
            we_q         <= we_i;
            f3_q         <= funct3_i;
            addr_q       <= addr_i;
            wdata_q      <= wdata_i;
            misaligned_o <= mis;
            timeout_o    <= 1'b0;
         end
         if (state == S_READ && mem_ack_i) begin
            word_q <= mem_data_i;
            if (!we_q) rdata_o <= load_data;
         end
         if ((state == S_READ || state == S_WRITE) && expired)
            timeout_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench with a transaction-level model of the load/store unit.
module tb_load_store_unit;

   localparam int ACK_T = 16;
   localparam int NEVER = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i, we_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, wdata_i;
   logic [31:0] rdata_o;
   logic        busy_o, done_o, misaligned_o, timeout_o;
   logic        mem_rd_en_o, mem_wr_en_o;
   logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
   logic        mem_ack_i;

   always #5 clk = ~clk;

   load_store_unit #(.ACK_TIMEOUT(ACK_T)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_i        (req_i),
      .we_i         (we_i),
      .funct3_i     (funct3_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rdata_o      (rdata_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .misaligned_o (misaligned_o),
      .timeout_o    (timeout_o),
      .mem_rd_en_o  (mem_rd_en_o),
      .mem_wr_en_o  (mem_wr_en_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i)
   );

   // Memory environment: ack after ack_delay waiting cycles of each access.
   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];
   bit          init_done = 0;
   int          ack_delay = 0;
   int          wait_cnt  = 0;

   function automatic logic [31:0] init_word(input int i);
      return 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
   endfunction

   assign mem_ack_i  = (mem_rd_en_o || mem_wr_en_o)
                    && (wait_cnt == ack_delay);
   assign mem_data_i = mem_rd_en_o ? mem[mem_addr_o[11:2]] : 32'd0;

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
         init_done <= 1;
      end else if (mem_wr_en_o && mem_ack_i) begin
         mem[mem_addr_o[11:2]] <= mem_data_o;
      end
      if ((mem_rd_en_o || mem_wr_en_o) && !mem_ack_i)
         wait_cnt <= wait_cnt + 1;
      else
         wait_cnt <= 0;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Protocol invariants on every cycle with a memory enable.
   always @(negedge clk) begin
      if (!rst && (mem_rd_en_o || mem_wr_en_o)) begin
         chk("one_enable", 32'(mem_rd_en_o & mem_wr_en_o), 0);
         chk("addr_align", 32'(mem_addr_o[1:0]), 0);
         chk("busy_en", 32'(busy_o), 1);
      end
   end

   // Reference model: plain byte-lane arithmetic.
   function automatic logic mis_of(input logic [2:0] f3,
                                   input logic [31:0] a);
      if (f3 == 3'b001 || f3 == 3'b101) return a[0];
      if (f3 == 3'b010) return a[1:0] != 0;
      return 0;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] w,
      input logic [2:0] f3, input logic [1:0] off);
      logic [31:0] s;
      s = w >> (8 * int'(off));
      case (f3)
         3'b000:  return {{24{s[7]}}, s[7:0]};
         3'b001:  return {{16{s[15]}}, s[15:0]};
         3'b100:  return s & 32'hFF;
         3'b101:  return s & 32'hFFFF;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w,
      input logic [31:0] wd, input logic [2:0] f3, input logic [1:0] off);
      logic [31:0] m;
      m = (f3 == 3'b000) ? 32'hFF : 32'hFFFF;
      m = m << (8 * int'(off));
      return (w & ~m) | ((wd << (8 * int'(off))) & m);
   endfunction

   logic [31:0] exp_rdata = 0;
   int last_lat, last_rd, last_wr;

   task automatic txn(input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int d);
      int idx, e_lat, e_rd, e_wr, k, rdc, wrc;
      logic e_mis, e_to, never, got;
      logic [31:0] w;
      idx   = int'(a[11:2]);
      never = (d >= ACK_T);
      e_mis = mis_of(f3, a);
      w     = ref_mem[idx];
      e_to  = 0; e_rd = 0; e_wr = 0;
      if (e_mis) begin
         e_lat = 1;
      end else if (we && f3 == 3'b010) begin
         e_wr  = never ? ACK_T : d + 1;
         e_lat = e_wr + 1;
         e_to  = never;
         if (!never) ref_mem[idx] = wd;
      end else if (!we) begin
         e_rd  = never ? ACK_T : d + 1;
         e_lat = e_rd + 1;
         e_to  = never;
         if (!never) exp_rdata = extract(w, f3, a[1:0]);
      end else if (never) begin
         e_rd  = ACK_T;
         e_lat = ACK_T + 1;
         e_to  = 1;
      end else begin
         e_rd  = d + 1;
         e_wr  = d + 1;
         e_lat = 2 * d + 3;
         ref_mem[idx] = merge(w, wd, f3, a[1:0]);
      end
      ack_delay = d;
      req_i = 1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
      @(posedge clk);
      #1;
      k = 0; rdc = 0; wrc = 0; got = 0;
      while (k < 60 && !got) begin
         req_i    = 1'($urandom_range(0, 1));
         we_i     = 1'($urandom_range(0, 1));
         funct3_i = 3'($urandom_range(0, 7));
         addr_i   = $urandom;
         wdata_i  = $urandom;
         @(negedge clk);
         k++;
         if (mem_rd_en_o) rdc++;
         if (mem_wr_en_o) wrc++;
         if (done_o) got = 1;
      end
      req_i = 0;
      last_lat = k; last_rd = rdc; last_wr = wrc;
      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL done_wait: got none want cycle %0d", e_lat);
      end else begin
         chk("latency", 32'(k), 32'(e_lat));
         chk("rd_cycles", 32'(rdc), 32'(e_rd));
         chk("wr_cycles", 32'(wrc), 32'(e_wr));
         chk("misaligned", 32'(misaligned_o), 32'(e_mis));
         chk("timeout", 32'(timeout_o), 32'(e_to));
         chk("rdata", rdata_o, exp_rdata);
         chk("mem_word", mem[idx], ref_mem[idx]);
      end
      @(negedge clk);
      chk("done_pulse", 32'(done_o), 0);
      chk("idle_after", 32'(busy_o), 0);
   endtask

   logic [2:0] f3_tab [5];

   initial begin
      int idx;
      logic we;
      logic [2:0] f3;
      logic [31:0] a;
      int d, r;
      f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      rst = 1; req_i = 0; we_i = 0; funct3_i = 0;
      addr_i = 0; wdata_i = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_flags", 32'({misaligned_o, timeout_o}), 0);
      chk("rst_mem", {30'd0, mem_rd_en_o, mem_wr_en_o}, 0);
      chk("rst_maddr", mem_addr_o | mem_data_o, 0);
      rst = 0;
      @(negedge clk);

      txn(1, 3'b010, 32'h100, 32'h8899AABB, 0);
      chk("lit_sw100_mem", mem[32'h40], 32'h8899AABB);
      txn(0, 3'b000, 32'h101, 0, 0);
      chk("lit_lb_rdata", rdata_o, 32'hFFFFFFAA);
      chk("lit_lb_lat", 32'(last_lat), 2);
      txn(0, 3'b100, 32'h103, 0, 0);
      chk("lit_lbu_rdata", rdata_o, 32'h00000088);
      txn(1, 3'b000, 32'h102, 32'h12345677, 0);
      chk("lit_sb_mem", mem[32'h40], 32'h8877AABB);
      chk("lit_sb_lat", 32'(last_lat), 3);
      chk("lit_sb_rw", 32'({last_rd, last_wr} == {32'd1, 32'd1}), 1);
      txn(1, 3'b010, 32'h200, 32'hDEADBEEF, 0);
      chk("lit_sw_rd", 32'(last_rd), 0);
      chk("lit_sw_wr", 32'(last_wr), 1);
      chk("lit_sw_lat", 32'(last_lat), 2);
      chk("lit_sw_mem", mem[32'h80], 32'hDEADBEEF);
      txn(0, 3'b001, 32'h103, 0, 0);
      chk("lit_mis_flag", 32'(misaligned_o), 1);
      chk("lit_mis_lat", 32'(last_lat), 1);
      chk("lit_mis_en", 32'(last_rd + last_wr), 0);
      txn(0, 3'b010, 32'h0, 0, NEVER);
      chk("lit_to_rd", 32'(last_rd), 16);
      chk("lit_to_flag", 32'(timeout_o), 1);
      chk("lit_to_rdata", rdata_o, 32'h00000088);
      txn(0, 3'b010, 32'h0, 0, ACK_T - 1);
      chk("lit_late_ack", 32'(timeout_o), 0);

      // Reset while an SB is waiting in READ.
      idx = 32'h300 >> 2;
      ack_delay = NEVER;
      req_i = 1; we_i = 1; funct3_i = 3'b000;
      addr_i = 32'h301; wdata_i = 32'h55;
      @(posedge clk);
      #1 req_i = 0;
      repeat (3) @(negedge clk);
      chk("rst_mid_rd", 32'(mem_rd_en_o), 1);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      exp_rdata = 0;
      @(negedge clk);
      chk("rst_mid_busy", 32'(busy_o), 0);
      chk("rst_mid_rdata", rdata_o, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_mid_quiet",
             32'({mem_wr_en_o, mem_rd_en_o, done_o}), 0);
      end
      chk("rst_mid_mem", mem[idx], ref_mem[idx]);

      for (int t = 0; t < 250; t++) begin
         we = 1'($urandom_range(0, 1));
         f3 = we ? f3_tab[$urandom_range(0, 2)]
                 : f3_tab[$urandom_range(0, 4)];
         a  = $urandom & 32'h0000_0FFF;
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
         r = $urandom_range(0, 19);
         if (r < 16)      d = $urandom_range(0, 3);
         else if (r < 18) d = ACK_T - 1;
         else             d = NEVER;
         txn(we, f3, a, $urandom, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 16, giving the maximum cycles spent waiting for mem_ack_i per memory access.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_i, input, 1 bit: core access request, sampled only in IDLE.
REQ-005 The block SHALL have port we_i, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have port funct3_i, input, 3 bits: access size and signedness (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 The block SHALL have port addr_i, input, 32 bits: byte address.
REQ-008 The block SHALL have port wdata_i, input, 32 bits: store data, right-aligned.
REQ-009 The block SHALL have port rdata_o, output, 32 bits: extended load result, held until the next done_o.
REQ-010 The block SHALL have ports busy_o, done_o, misaligned_o and timeout_o, each output, 1 bit: state not IDLE; one-cycle completion pulse; error flag; error flag. Both error flags are valid with done_o.
REQ-011 The block SHALL have ports mem_rd_en_o, mem_wr_en_o, mem_addr_o[31:0], mem_data_o[31:0] (outputs) and mem_data_i[31:0], mem_ack_i (inputs): the word-memory side.

Function
REQ-012 The FSM SHALL have states IDLE, READ, WRITE and RESP; busy_o = (state != IDLE).
REQ-013 In IDLE with req_i=1, the block SHALL latch we_i, funct3_i, addr_i and wdata_i, then transition:
- misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) -> RESP with misaligned_o=1;
- load, SB or SH -> READ;
- SW -> WRITE.
REQ-014 req_i outside IDLE SHALL be ignored.
REQ-015 mem_addr_o SHALL equal {addr[31:2],2'b00} in READ and WRITE; mem_rd_en_o SHALL be 1 only in READ and mem_wr_en_o 1 only in WRITE, never both; all are 0 elsewhere.
REQ-016 READ on mem_ack_i SHALL capture mem_data_i, then go to RESP for a load or to WRITE for a store.
REQ-017 Load extraction SHALL be little-endian: the byte lane is addr[1:0] and the half lane is addr[1]; B/H sign-extend, BU/HU zero-extend.
REQ-018 The store merge SHALL work as follows:
- SB replaces byte lane addr[1:0] of the captured word with wdata[7:0];
- SH replaces half lane addr[1] with wdata[15:0];
- SW drives wdata unmodified on mem_data_o.
REQ-019 WRITE on mem_ack_i SHALL go to RESP.
REQ-020 A timeout counter SHALL clear on entry to READ or WRITE; after ACK_TIMEOUT cycles without ack, the block SHALL go to RESP with timeout_o=1, perform no write, and leave rdata_o unchanged.
REQ-021 RESP SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-022 Latency with ack always 1, counted as done_o cycle after the req_i sampling edge, SHALL be: load or SW = 2; SB/SH = 3; misaligned = 1.
REQ-023 Error flags SHALL clear on the next accepted request.

Reset
REQ-024 When rst is 1, the block SHALL, at the next edge, enter state IDLE and clear rdata_o, done_o, misaligned_o, timeout_o, the counter and all mem_* outputs to 0.
REQ-025 Reset mid-operation SHALL abort without completion; a write already enabled in the reset cycle commits at that edge, and no later access occurs.

Structure
REQ-026 The funct3 encodings, state encodings and the ACK_TIMEOUT default SHALL live in shared package lsu_pkg.
REQ-027 Extraction and merge SHALL be one combinational sub-module, lsu_align; the FSM and counter stay in load_store_unit.

Verification
REQ-028 Word 0x100 = 0x8899AABB: LB at 0x101 -> rdata_o 0xFFFFFFAA at cycle 2; LBU at 0x103 -> 0x00000088.
REQ-029 SB at 0x102, wdata 0x12345677, on 0x8899AABB -> one READ cycle then one WRITE cycle; memory word = 0x8877AABB; done_o at cycle 3.
REQ-030 SW at 0x200, wdata 0xDEADBEEF -> mem_rd_en_o never 1; mem_wr_en_o 1 for one cycle; done_o at cycle 2.
REQ-031 LH at 0x103 -> misaligned_o=1 with done_o at cycle 1; no mem enable at any time.
REQ-032 mem_ack_i tied 0, LW at 0x0 -> 16 READ cycles, then timeout_o=1 with done_o; rdata_o unchanged.
REQ-033 rst pulsed during READ of an SB -> mem_wr_en_o never 1, busy_o=0 on the next cycle, and the memory word is unchanged.
